rx_sample_ring_ctrl: RTL

//  Circular-buffer controller for the RX sample RAM: writes every incoming 16-bit
//  RX sample into a 128-deep ring and, on request, streams a window of the most

---
 rtl/rx_buf_pkg.sv | 23 ++
 rtl/rx_BRAM_16_128.sv | 51 +++++
 rtl/rx_sample_ring_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/rx_buf_pkg.sv
// Shared constants and FSM encoding for the RX sample ring buffer.
package rx_buf_pkg;

  localparam int DEPTH = 128;  // ring depth in samples
  localparam int AW    = 7;    // ring address width, log2(DEPTH)
  localparam int DW    = 16;   // sample width
  localparam int LW    = 8;    // lag/length/fill width, holds 0..DEPTH

  // Window-read sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Ring address 'lag' samples behind 'ptr'. A lag of DEPTH folds to zero,
  // i.e. the slot the next write would overwrite, which is the oldest sample.
  function automatic logic [AW-1:0] ring_sub(input logic [AW-1:0] ptr,
                                             input logic [LW-1:0] lag);
    return ptr - lag[AW-1:0];
  endfunction

endpackage

// File: rtl/rx_BRAM_16_128.sv
// 128 x 16 simple dual-port sample RAM: port a writes, port b reads with a
// one-cycle registered output. Read-first on a same-address collision.
module rx_BRAM_16_128
  import rx_buf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dia,
  input  logic          enb,
  input  logic [AW-1:0] addrb,
  output logic [DW-1:0] dob
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] dob_q;
  logic [DW-1:0] dob_d;

  // Write port: store the sample when port a is enabled for writing.
  // NOTE: the array has no reset branch on purpose; a reset loop over the
  // array would stop it mapping onto block RAM. Stale contents are harmless
  // because the controller's fill count gates what can be read.
  always_ff @(posedge clk) begin
    if (ena && wea) begin
      mem_q[addra] <= dia;
    end
  end

  // Next read-register value: load on enable, otherwise hold.
  always_comb begin
    dob_d = dob_q;
    if (enb) begin
      dob_d = mem_q[addrb];
    end
  end

  // Read register: with non-blocking assignment the array is sampled before
  // this cycle's write lands, which gives read-first collision behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      dob_q <= '0;
    end else begin
      dob_q <= dob_d;
    end
  end

  assign dob = dob_q;

endmodule

// File: rtl/rx_sample_ring_ctrl.sv
// Circular-buffer controller for the RX sample RAM. Every incoming sample is
// written into a 128-deep ring; on request a window of recent samples is
// streamed back out oldest-first.
module rx_sample_ring_ctrl
  import rx_buf_pkg::*;
(
  input  logic          clk,
  input  logic          rrx_rst,
  input  logic          smp_valid,
  input  logic [DW-1:0] smp_data,
  input  logic          rd_start,
  input  logic [LW-1:0] rd_lag,
  input  logic [LW-1:0] rd_len,
  output logic          rd_busy,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          rd_err,
  output logic [LW-1:0] fill_cnt
);

  localparam logic [LW-1:0] FILL_MAX = LW'(DEPTH);

  // Write-side state.
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] fill_q,   fill_d;

  // Read-side state.
  rd_state_e     state_q,  state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] rem_q,    rem_d;
  logic          valid_q,  valid_d;
  logic          last_q,   last_d;
  logic          err_q,    err_d;

  logic          req_ok;
  logic          enb;
  logic          last_issue;
  logic [DW-1:0] dob;

  // Request qualification against the samples currently held in the ring.
  always_comb begin
    req_ok = (rd_lag != '0) && (rd_lag <= fill_q) &&
             (rd_len != '0) && (rd_len <= rd_lag);
  end

  // Write pointer and fill counter; writes are never stalled.
  // NOTE: every output of a combinational block gets a default before any
  // branch, otherwise an unassigned path infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    if (smp_valid) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + LW'(1);
      end
    end
  end

  // Window sequencer: accept or reject requests, issue one RAM read per
  // cycle in READ, and wait one cycle in DRAIN for the final data.
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    rem_d      = rem_q;
    err_d      = 1'b0;
    enb        = 1'b0;
    last_issue = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          if (req_ok) begin
            state_d  = READ;
            rd_ptr_d = ring_sub(wr_ptr_q, rd_lag);
            rem_d    = rd_len;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      READ: begin
        enb      = 1'b1;
        rd_ptr_d = rd_ptr_q + AW'(1);
        rem_d    = rem_q - LW'(1);
        err_d    = rd_start;
        if (rem_q == LW'(1)) begin
          last_issue = 1'b1;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        err_d   = rd_start;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Data returns one cycle after issue, so valid/last trail enb by one.
    valid_d = enb;
    last_d  = last_issue;
  end

  // All controller state, including the registered valid/last/err outputs.
  // Synchronous reset aborts any window in flight.
  always_ff @(posedge clk) begin
    if (rrx_rst) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      rem_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      rem_q    <= rem_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  rx_BRAM_16_128 u_ring_ram (
    .clk   (clk),
    .rst   (rrx_rst),
    .ena   (smp_valid),
    .wea   (smp_valid),
    .addra (wr_ptr_q),
    .dia   (smp_data),
    .enb   (enb),
    .addrb (rd_ptr_q),
    .dob   (dob)
  );

  assign rd_busy  = (state_q != IDLE);
  assign rd_valid = valid_q;
  assign rd_last  = last_q;
  assign rd_err   = err_q;
  assign rd_data  = dob;
  assign fill_cnt = fill_q;

endmodule
